// File: rtl/eth_helper_pkg.sv
// Shared definitions for the snoop-stream path: stream type codes, the
// arbiter state encoding and the arbiter's output FIFO entry layout.
package eth_helper_pkg;

    localparam logic [2:0] STREAM_AW = 3'b010;
    localparam logic [2:0] STREAM_W  = 3'b011;
    localparam logic [2:0] STREAM_AR = 3'b100;
    localparam logic [2:0] STREAM_R  = 3'b101;
    localparam logic [2:0] STREAM_B  = 3'b110;

    // Field widths of the FIFO entry; the arbiter's DATA_WIDTH/SRC_ID_WIDTH must match.
    localparam int ARB_DATA_WIDTH   = 128;
    localparam int ARB_SRC_ID_WIDTH = 3;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_LOCKED = 2'd1,
        ARB_ABORT  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                        abort;
        logic [ARB_SRC_ID_WIDTH-1:0] src_id;
        logic                        last;
        logic [ARB_DATA_WIDTH-1:0]   data;
    } arb_entry_t;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO with registered occupancy count; writes while full and
// reads while empty are ignored. DEPTH must be a power of two, >= 2.
module stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             wr_fire;
    logic             rd_fire;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign wr_fire = wr_en & ~full;
    assign rd_fire = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count/pointers define validity, and this keeps it RAM-mappable.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/axis_stream_arbiter.sv
// Burst-locked round-robin merge of the converter snoop streams into one AXI-Stream.
// Define AXIS_STREAM_ARBITER_ABORT_CNT_EN to add the saturating abort_count output.
module axis_stream_arbiter
    import eth_helper_pkg::*;
#(
    parameter int DATA_WIDTH   = ARB_DATA_WIDTH,
    parameter int NUM_SOURCES  = 5,
    parameter int FIFO_DEPTH   = 8,
    parameter int SRC_ID_WIDTH = ARB_SRC_ID_WIDTH
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [NUM_SOURCES-1:0]            src_valid,
    input  logic [NUM_SOURCES-1:0]            src_in_progress,
    input  logic [NUM_SOURCES-1:0]            src_last,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0] src_data,
    output logic [NUM_SOURCES-1:0]            src_ready,
    output logic [DATA_WIDTH-1:0]             m_axis_tdata,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    output logic [SRC_ID_WIDTH-1:0]           m_axis_tid,
    output logic                              m_axis_tuser,
    input  logic                              m_axis_tready
`ifdef AXIS_STREAM_ARBITER_ABORT_CNT_EN
    ,
    output logic [15:0]                       abort_count
`endif
);

    localparam int ENTRY_W = $bits(arb_entry_t);

    arb_state_t              state;
    logic [SRC_ID_WIDTH-1:0] owner;
    logic [SRC_ID_WIDTH-1:0] rr_ptr;
    logic [SRC_ID_WIDTH-1:0] cand;
    logic [SRC_ID_WIDTH-1:0] sel;
    logic                    cand_found;
    logic                    accept;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    wr_en;
    arb_entry_t              wr_entry;
    logic [ENTRY_W-1:0]      rd_data;
    arb_entry_t              head;

    function automatic logic [SRC_ID_WIDTH-1:0] next_src(input logic [SRC_ID_WIDTH-1:0] id);
        if (int'(id) >= NUM_SOURCES - 1) return '0;
        return id + 1'b1;
    endfunction

    // First valid source at or after rr_ptr, wrapping past the highest index.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        int idx;
        idx        = 0;
        cand_found = 1'b0;
        cand       = '0;
        for (int k = 0; k < NUM_SOURCES; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_SOURCES) idx = idx - NUM_SOURCES;
            if (!cand_found && src_valid[idx]) begin
                cand_found = 1'b1;
                cand       = SRC_ID_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        src_ready = '0;
        case (state)
            ARB_IDLE:   if (cand_found && !fifo_full) src_ready[cand] = 1'b1;
            ARB_LOCKED: if (!fifo_full) src_ready[owner] = 1'b1;
            default:    src_ready = '0;
        endcase
    end

    assign sel    = (state == ARB_IDLE) ? cand : owner;
    assign accept = |(src_valid & src_ready);

    always_comb begin
        wr_en    = 1'b0;
        wr_entry = '0;
        if (state == ARB_ABORT) begin
            wr_en           = ~fifo_full;
            wr_entry.abort  = 1'b1;
            wr_entry.src_id = owner;
            wr_entry.last   = 1'b1;
        end else if (accept) begin
            wr_en           = 1'b1;
            wr_entry.src_id = sel;
            wr_entry.last   = src_last[sel];
            wr_entry.data   = src_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= ARB_IDLE;
            owner  <= '0;
            rr_ptr <= '0;
`ifdef AXIS_STREAM_ARBITER_ABORT_CNT_EN
            abort_count <= '0;
`endif
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (accept) begin
                        owner <= cand;
                        if (src_last[cand]) rr_ptr <= next_src(cand);
                        else                state  <= ARB_LOCKED;
                    end
                end
                ARB_LOCKED: begin
                    if (accept) begin
                        if (src_last[owner]) begin
                            state  <= ARB_IDLE;
                            rr_ptr <= next_src(owner);
                        end
                    end else if (!src_in_progress[owner]) begin
                        // Owner restarted after a stall; its partial burst must be closed off.
                        state <= ARB_ABORT;
                    end
                end
                ARB_ABORT: begin
                    if (!fifo_full) begin
                        state  <= ARB_IDLE;
                        rr_ptr <= next_src(owner);
`ifdef AXIS_STREAM_ARBITER_ABORT_CNT_EN
                        if (abort_count != 16'hFFFF) abort_count <= abort_count + 1'b1;
`endif
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    stream_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (wr_en),
        .wr_data (wr_entry),
        .full    (fifo_full),
        .rd_en   (m_axis_tready),
        .rd_data (rd_data),
        .empty   (fifo_empty)
    );

    // Unwritten storage must not leak onto the bus while empty.
    assign head          = fifo_empty ? '0 : arb_entry_t'(rd_data);
    assign m_axis_tvalid = ~fifo_empty;
    assign m_axis_tdata  = head.data;
    assign m_axis_tlast  = head.last;
    assign m_axis_tid    = head.src_id;
    assign m_axis_tuser  = head.abort;

endmodule

// File: tb/tb_axis_stream_arbiter.sv
// Scoreboard bench for axis_stream_arbiter: per-source beat queues feed the DUT,
// expected output beats are queued at load time and compared as they leave.
module tb_axis_stream_arbiter;

    localparam int DW    = 128;
    localparam int NS    = 5;
    localparam int IDW   = 3;

    typedef struct { logic [DW-1:0] data; logic last; } beat_t;
    typedef struct { logic [DW-1:0] data; logic last; logic [IDW-1:0] tid; logic user; } exp_t;
    typedef struct { int src; int cyc; } acc_t;

    logic              clk;
    logic              resetn;
    logic [NS-1:0]     src_valid;
    logic [NS-1:0]     src_in_progress;
    logic [NS-1:0]     src_last;
    logic [NS*DW-1:0]  src_data;
    logic [NS-1:0]     src_ready;
    logic [DW-1:0]     m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic [IDW-1:0]    m_axis_tid;
    logic              m_axis_tuser;
    logic              m_axis_tready;
`ifdef AXIS_STREAM_ARBITER_ABORT_CNT_EN
    logic [15:0]       abort_count;
`endif

    beat_t         src_q [NS][$];
    logic [NS-1:0] mid;
    logic [NS-1:0] drop;
    logic [NS-1:0] acc_mask;
    exp_t          sb[$];
    acc_t          acc_log[$];
    int            acc_cyc_q[$];
    int            cyc;
    int            vectors;
    int            miscompares;
    int            acc_cnt;
    bit            lat_check;
    bit            prev_hold;
    exp_t          prev_out;

    axis_stream_arbiter dut (
        .clk             (clk),
        .resetn          (resetn),
        .src_valid       (src_valid),
        .src_in_progress (src_in_progress),
        .src_last        (src_last),
        .src_data        (src_data),
        .src_ready       (src_ready),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tid      (m_axis_tid),
        .m_axis_tuser    (m_axis_tuser),
        .m_axis_tready   (m_axis_tready)
`ifdef AXIS_STREAM_ARBITER_ABORT_CNT_EN
        ,
        .abort_count     (abort_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Source model: pops beats the DUT accepted, then presents the next head.
    always @(posedge clk) begin
        beat_t b;
        #1;
        for (int i = 0; i < NS; i++) begin
            if (acc_mask[i] && src_q[i].size() > 0) begin
                b = src_q[i].pop_front();
                mid[i] = !b.last;
            end
            if (drop[i] && src_q[i].size() == 0) begin
                mid[i]  = 1'b0;
                drop[i] = 1'b0;
            end
            if (src_q[i].size() > 0) begin
                src_valid[i]           = 1'b1;
                src_last[i]            = src_q[i][0].last;
                src_data[i*DW +: DW]   = src_q[i][0].data;
            end else begin
                src_valid[i]           = 1'b0;
                src_last[i]            = 1'b0;
                src_data[i*DW +: DW]   = '0;
            end
            src_in_progress[i] = mid[i];
        end
    end

    // Output monitor: handshake log, one-hot grant, hold-stable and scoreboard compare.
    always @(negedge clk) begin
        exp_t e;
        int   a;
        acc_mask = src_valid & src_ready;
        if (resetn) begin
            vectors++;
            if (!$onehot0(src_ready)) begin
                miscompares++;
                $display("FAIL grant_onehot: src_ready=%b needs at most one bit", src_ready);
            end
            for (int i = 0; i < NS; i++) begin
                if (acc_mask[i]) begin
                    acc_cnt++;
                    acc_log.push_back('{i, cyc});
                    acc_cyc_q.push_back(cyc);
                end
            end
            if (prev_hold) begin
                vectors++;
                if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tid, m_axis_tuser} !==
                    {1'b1, prev_out.data, prev_out.last, prev_out.tid, prev_out.user}) begin
                    miscompares++;
                    $display("FAIL hold_stable: output changed while stalled, tid=%0d data=%h, was tid=%0d data=%h",
                             m_axis_tid, m_axis_tdata, prev_out.tid, prev_out.data);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_beat: tid=%0d data=%h with empty scoreboard", m_axis_tid, m_axis_tdata);
                end else begin
                    e = sb.pop_front();
                    if ({m_axis_tdata, m_axis_tlast, m_axis_tid, m_axis_tuser} !== {e.data, e.last, e.tid, e.user}) begin
                        miscompares++;
                        $display("FAIL out_beat: got tid=%0d last=%b user=%b data=%h, expected tid=%0d last=%b user=%b data=%h",
                                 m_axis_tid, m_axis_tlast, m_axis_tuser, m_axis_tdata, e.tid, e.last, e.user, e.data);
                    end
                end
                if (lat_check) begin
                    vectors++;
                    a = (acc_cyc_q.size() > 0) ? acc_cyc_q.pop_front() : -10;
                    if (cyc != a + 1) begin
                        miscompares++;
                        $display("FAIL latency: output in cycle %0d, expected cycle %0d", cyc, a + 1);
                    end
                end
            end
            prev_hold     = m_axis_tvalid && !m_axis_tready;
            prev_out.data = m_axis_tdata;
            prev_out.last = m_axis_tlast;
            prev_out.tid  = m_axis_tid;
            prev_out.user = m_axis_tuser;
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load_burst(input int s, input int n, input bit with_last);
        beat_t b;
        exp_t  e;
        for (int k = 0; k < n; k++) begin
            b.data = {$urandom, $urandom, $urandom, $urandom};
            b.last = with_last && (k == n - 1);
            src_q[s].push_back(b);
            e.data = b.data;
            e.last = b.last;
            e.tid  = IDW'(s);
            e.user = 1'b0;
            sb.push_back(e);
        end
    endtask

    function automatic bit all_q_empty();
        for (int i = 0; i < NS; i++) if (src_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_drain(input int budget, input string tag);
        int n;
        n = 0;
        while (!(sb.size() == 0 && all_q_empty() && !m_axis_tvalid)) begin
            @(negedge clk);
            n++;
            if (n > budget) begin
                vectors++;
                miscompares++;
                $display("FAIL %s_timeout: %0d beats still expected after %0d cycles", tag, sb.size(), budget);
                break;
            end
        end
    endtask

    task automatic check_order(input string tag, input int exp_src[$], input bit consecutive);
        vectors++;
        if (acc_log.size() != exp_src.size()) begin
            miscompares++;
            $display("FAIL %s_count: %0d beats accepted, expected %0d", tag, acc_log.size(), exp_src.size());
        end else begin
            for (int k = 0; k < exp_src.size(); k++) begin
                vectors++;
                if (acc_log[k].src != exp_src[k] ||
                    (consecutive && acc_log[k].cyc != acc_log[0].cyc + k)) begin
                    miscompares++;
                    $display("FAIL %s_grant%0d: src %0d in cycle %0d, expected src %0d in cycle %0d",
                             tag, k, acc_log[k].src, acc_log[k].cyc, exp_src[k],
                             consecutive ? acc_log[0].cyc + k : acc_log[k].cyc);
                end
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        vectors++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser} !== 3'b000 || m_axis_tdata !== '0 ||
            m_axis_tid !== '0 || src_ready !== '0) begin
            miscompares++;
            $display("FAIL %s: tvalid=%b tlast=%b tuser=%b tid=%0d tdata=%h src_ready=%b, all required zero",
                     tag, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tid, m_axis_tdata, src_ready);
        end
    endtask

    task automatic test_reset();
        resetn        = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset_outputs");
`ifdef AXIS_STREAM_ARBITER_ABORT_CNT_EN
        vectors++;
        if (abort_count !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_abort_count: got %0d expected 0", abort_count);
        end
`endif
        step();
        resetn = 1'b1;
    endtask

    task automatic test_round_robin();
        step();
        acc_log.delete();
        load_burst(0, 2, 1'b1);
        load_burst(2, 2, 1'b1);
        load_burst(0, 2, 1'b1);
        wait_drain(40, "rr");
        check_order("rr", '{0, 0, 2, 2, 0, 0}, 1'b1);
    endtask

    task automatic test_single_burst();
        step();
        acc_log.delete();
        acc_cyc_q.delete();
        lat_check = 1'b1;
        load_burst(1, 3, 1'b1);
        wait_drain(20, "single");
        lat_check = 1'b0;
        check_order("single", '{1, 1, 1}, 1'b1);
    endtask

    task automatic test_burst_lock();
        step();
        acc_log.delete();
        load_burst(3, 3, 1'b1);
        load_burst(4, 2, 1'b1);
        wait_drain(30, "lock");
        check_order("lock", '{3, 3, 3, 4, 4}, 1'b1);
    endtask

    task automatic test_back_pressure();
        int c0;
        step();
        m_axis_tready = 1'b0;
        c0 = acc_cnt;
        load_burst(0, 9, 1'b1);
        repeat (14) @(negedge clk);
        vectors++;
        if (acc_cnt - c0 != 8 || src_ready !== '0 || src_valid[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_full: accepted=%0d src_ready=%b valid0=%b, expected 8 beats, ready 0, valid 1",
                     acc_cnt - c0, src_ready, src_valid[0]);
        end
        step();
        m_axis_tready = 1'b1;
        wait_drain(30, "bp");
        vectors++;
        if (acc_cnt - c0 != 9) begin
            miscompares++;
            $display("FAIL bp_total: accepted=%0d expected 9", acc_cnt - c0);
        end
    endtask

    task automatic test_abort();
        int   c0;
        exp_t m;
        step();
        m_axis_tready = 1'b0;
        c0 = acc_cnt;
        load_burst(1, 6, 1'b1);
        load_burst(3, 2, 1'b0);
        drop[3] = 1'b1;
        m.data = '0;
        m.last = 1'b1;
        m.tid  = 3'd3;
        m.user = 1'b1;
        sb.push_back(m);
        load_burst(4, 1, 1'b1);
        repeat (16) @(negedge clk);
        vectors++;
        if (acc_cnt - c0 != 8 || src_ready !== '0 || m_axis_tvalid !== 1'b1 ||
            m_axis_tid !== 3'd1 || m_axis_tuser !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_hold: accepted=%0d src_ready=%b tvalid=%b tid=%0d tuser=%b, expected 8, 0, 1, 1, 0",
                     acc_cnt - c0, src_ready, m_axis_tvalid, m_axis_tid, m_axis_tuser);
        end
`ifdef AXIS_STREAM_ARBITER_ABORT_CNT_EN
        vectors++;
        if (abort_count !== 16'd0) begin
            miscompares++;
            $display("FAIL abort_count_pending: got %0d expected 0", abort_count);
        end
`endif
        step();
        m_axis_tready = 1'b1;
        wait_drain(40, "abort");
        vectors++;
        if (acc_cnt - c0 != 9) begin
            miscompares++;
            $display("FAIL abort_total: accepted=%0d expected 9", acc_cnt - c0);
        end
`ifdef AXIS_STREAM_ARBITER_ABORT_CNT_EN
        vectors++;
        if (abort_count !== 16'd1) begin
            miscompares++;
            $display("FAIL abort_count: got %0d expected 1", abort_count);
        end
`endif
    endtask

    task automatic test_reset_mid_burst();
        int c0;
        int n;
        step();
        load_burst(2, 1, 1'b1);
        wait_drain(20, "pre_reset");
        step();
        m_axis_tready = 1'b0;
        c0 = acc_cnt;
        load_burst(3, 5, 1'b1);
        n = 0;
        while (acc_cnt - c0 < 3) begin
            @(negedge clk);
            n++;
            if (n > 20) begin
                vectors++;
                miscompares++;
                $display("FAIL rst_mid_timeout: only %0d beats accepted", acc_cnt - c0);
                break;
            end
        end
        step();
        resetn = 1'b0;
        for (int i = 0; i < NS; i++) src_q[i].delete();
        mid             = '0;
        drop            = '0;
        src_valid       = '0;
        src_in_progress = '0;
        src_last        = '0;
        src_data        = '0;
        sb.delete();
        @(negedge clk);
        check_idle_outputs("rst_mid_outputs");
        repeat (2) @(posedge clk);
        #2;
        resetn        = 1'b1;
        m_axis_tready = 1'b1;
        acc_log.delete();
        load_burst(0, 1, 1'b1);
        load_burst(3, 1, 1'b1);
        wait_drain(20, "post_reset");
        check_order("post_reset", '{0, 3}, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors         = 0;
        miscompares     = 0;
        acc_cnt         = 0;
        cyc             = 0;
        lat_check       = 1'b0;
        prev_hold       = 1'b0;
        mid             = '0;
        drop            = '0;
        acc_mask        = '0;
        src_valid       = '0;
        src_in_progress = '0;
        src_last        = '0;
        src_data        = '0;
        m_axis_tready   = 1'b1;
        resetn          = 1'b0;

        test_reset();
        test_round_robin();
        test_single_burst();
        test_burst_lock();
        test_back_pressure();
        test_abort();
        test_reset_mid_burst();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
